ui_bus_arbiter: RTL and testbench

- Two-requester arbiter that shares the single memory-mapped UI device port (keys, switches, LEDR, HEX) between the CPU load/store path (port A) and a secondary master such as the debug monitor or display refresher (port B).
- It serializes accesses and drives the UI controller's wrtEn, uiDevice and in inputs for exactly one cycle per access.
- It captures the UI controller's out value and returns it to the granted requester with a one-cycle ack.

---
 rtl/ui_bus_arbiter.sv | 86 ++++++++
 tb/tb_ui_bus_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ui_bus_arbiter.sv
// ui_bus_arbiter: round-robin arbiter sharing the UI device port between two masters
module ui_bus_arbiter #(
    parameter int DBITS   = 32,
    parameter int DEVBITS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a_req,
    input  logic               a_wr,
    input  logic [DEVBITS-1:0] a_dev,
    input  logic [DBITS-1:0]   a_wdata,
    output logic               a_ack,
    output logic [DBITS-1:0]   a_rdata,
    input  logic               b_req,
    input  logic               b_wr,
    input  logic [DEVBITS-1:0] b_dev,
    input  logic [DBITS-1:0]   b_wdata,
    output logic               b_ack,
    output logic [DBITS-1:0]   b_rdata,
    output logic               ui_wrtEn,
    output logic [DEVBITS-1:0] ui_device,
    output logic [DBITS-1:0]   ui_in,
    input  logic [DBITS-1:0]   ui_out,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state;
    logic   last_b;
    logic   gnt_b;
    logic   pick_b;

    // B wins if it is the only requester, or on a tie when A was served last
    always_comb pick_b = b_req & (~a_req | ~last_b);

    // The ui_* registers double as the latched request fields: loaded at grant,
    // presented throughout ACCESS, and left in place afterwards with wrtEn low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            gnt_b     <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            ui_wrtEn  <= 1'b0;
            ui_device <= '0;
            ui_in     <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (a_req | b_req) begin
                    gnt_b     <= pick_b;
                    last_b    <= pick_b;
                    ui_wrtEn  <= pick_b ? b_wr : a_wr;
                    ui_device <= pick_b ? b_dev : a_dev;
                    ui_in     <= pick_b ? b_wdata : a_wdata;
                    state     <= ACCESS;
                    busy      <= 1'b1;
                end
                ACCESS: begin
                    ui_wrtEn <= 1'b0;
                    if (gnt_b) begin
                        b_rdata <= ui_out;
                        b_ack   <= 1'b1;
                    end else begin
                        a_rdata <= ui_out;
                        a_ack   <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ui_bus_arbiter.sv
// tb_ui_bus_arbiter: directed-vector bench with a behavioural UI controller model
module tb_ui_bus_arbiter;
    localparam logic [1:0] UI_KEY = 2'd0, UI_SW = 2'd1, UI_LEDR = 2'd2, UI_HEX = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
    logic [1:0]  a_dev = '0, b_dev = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic        a_ack, b_ack, ui_wrtEn, busy;
    logic [31:0] a_rdata, b_rdata, ui_in, ui_out;
    logic [1:0]  ui_device;

    logic [31:0] key = 32'h0000_0005, sw = '0, led = '0, hex = '0;
    int          total = 0, passed = 0;

    ui_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_wr(a_wr), .a_dev(a_dev), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_dev(b_dev), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .ui_wrtEn(ui_wrtEn), .ui_device(ui_device), .ui_in(ui_in), .ui_out(ui_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // UI controller model: writes land on the falling edge, reads are combinational
    always @(negedge clk)
        if (ui_wrtEn) begin
            if (ui_device == UI_LEDR) led = ui_in;
            if (ui_device == UI_HEX) hex = ui_in;
        end

    always_comb
        ui_out = ui_device == UI_KEY ? key : ui_device == UI_SW ? sw : ui_device == UI_LEDR ? led : hex;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset then idle
        repeat (3) step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_acks", {30'd0, a_ack, b_ack}, 32'd0);
            check("idle_wrt_busy", {30'd0, ui_wrtEn, busy}, 32'd0);
        end
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_b_rdata", b_rdata, 32'd0);

        // single write A -> LEDR
        a_req = 1; a_wr = 1; a_dev = UI_LEDR; a_wdata = 32'h2A5;
        step();
        check("wr_acc_wrten", ui_wrtEn, 1);
        check("wr_acc_dev", ui_device, UI_LEDR);
        check("wr_acc_in", ui_in, 32'h2A5);
        check("wr_acc_busy", busy, 1);
        check("wr_acc_ack", a_ack, 0);
        step();
        check("wr_done_ack", {30'd0, a_ack, b_ack}, 32'd2);
        check("wr_done_wrten", ui_wrtEn, 0);
        check("wr_led", led, 32'h2A5);
        check("wr_a_rdata", a_rdata, 32'h2A5);
        a_req = 0;
        step();
        check("wr_idle_ack", a_ack, 0);
        check("wr_idle_busy", busy, 0);

        // single read B <- SW
        sw = 32'h155;
        b_req = 1; b_wr = 0; b_dev = UI_SW;
        step();
        check("rd_acc_wrten", ui_wrtEn, 0);
        check("rd_acc_dev", ui_device, UI_SW);
        step();
        check("rd_done_ack", {30'd0, a_ack, b_ack}, 32'd1);
        check("rd_b_rdata", b_rdata, 32'h155);
        check("rd_a_kept", a_rdata, 32'h2A5);
        b_req = 0;
        step();

        // contention: A writes HEX, B reads HEX, round-robin A,B,A,B
        a_req = 1; a_wr = 1; a_dev = UI_HEX; a_wdata = 32'h1234;
        b_req = 1; b_wr = 0; b_dev = UI_HEX;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_acc_wrten", ui_wrtEn, (k % 2 == 0) ? 1 : 0);
            step();
            check("rr_ack", {30'd0, a_ack, b_ack}, (k % 2 == 0) ? 32'd2 : 32'd1);
            if (k == 1) check("rr_b_rdata", b_rdata, 32'h1234);
            if (k == 3) begin a_req = 0; b_req = 0; end
            step();
            check("rr_gap_ack", {30'd0, a_ack, b_ack}, 32'd0);
        end
        check("rr_hex", hex, 32'h1234);

        // request dropped during ACCESS
        a_req = 1; a_wr = 1; a_dev = UI_LEDR; a_wdata = 32'h0F0;
        step();
        a_req = 0;
        step();
        check("drop_ack", a_ack, 1);
        check("drop_led", led, 32'h0F0);
        step();
        check("drop_ack_end", a_ack, 0);
        step();
        check("drop_no_regrant", {30'd0, busy, ui_wrtEn}, 32'd0);

        // reset during ACCESS of a HEX write
        a_req = 1; a_wr = 1; a_dev = UI_HEX; a_wdata = 32'hBEEF;
        step();
        check("rst_acc_wrten", ui_wrtEn, 1);
        #1 reset = 0;
        #1;
        check("rst_async_wrten", ui_wrtEn, 0);
        check("rst_async_busy", busy, 0);
        a_req = 0;
        step();
        check("rst_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
        check("rst_hex_lost", hex, 32'h1234);
        check("rst_a_rdata_clr", a_rdata, 32'd0);
        reset = 1;
        a_req = 1; a_wr = 1; a_dev = UI_LEDR; a_wdata = 32'h3C3;
        b_req = 1; b_wr = 0; b_dev = UI_KEY;
        step();
        check("post_rst_tie_dev", ui_device, UI_LEDR);
        step();
        check("post_rst_ack", {30'd0, a_ack, b_ack}, 32'd2);
        check("post_rst_rdata", a_rdata, 32'h3C3);
        a_req = 0; b_req = 0;
        step();
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
